// File: rtl/psx_pkg.sv
// Shared constants, FSM state type and tx byte selection for the PSX pad responder.
package psx_pkg;

    localparam logic [7:0]  PSX_HIZ_BYTE   = 8'hFF;
    localparam logic [7:0]  PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0]  PSX_ID_READY   = 8'h5A;
    localparam logic [7:0]  PSX_CMD_START  = 8'h01;
    localparam logic [7:0]  PSX_CMD_POLL   = 8'h42;
    localparam int unsigned PSX_POLL_BYTES = 5;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ACK_WAIT,
        ACK_PULSE,
        DONE,
        IGNORE
    } psx_state_t;

    function automatic logic [7:0] psx_tx_byte(input logic [2:0] idx, input logic [15:0] snap);
        case (idx)
            3'd0:    return PSX_HIZ_BYTE;
            3'd1:    return PSX_ID_DIGITAL;
            3'd2:    return PSX_ID_READY;
            3'd3:    return snap[7:0];
            default: return snap[15:8];
        endcase
    endfunction

endpackage

// File: rtl/psx_pad_responder_sync.sv
// Two-flop synchronizer plus an edge register; rise/fall are single-cycle pulses.
module psx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/psx_pad_responder.sv
// Controller-side PSX digital pad responder, oversampling the link on clk.
// Define PSX_PAD_ADDR_CHECK_EN to ignore selections not starting with 0x01 0x42.
module psx_pad_responder
    import psx_pkg::*;
#(
    parameter int unsigned ACK_DELAY = 2,
    parameter int unsigned ACK_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    input  logic [15:0] btn,
    output logic        data,
    output logic        ack,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid
);

    localparam logic [7:0] DELAY_LAST = (ACK_DELAY == 0) ? 8'd0 : 8'(ACK_DELAY - 1);
    localparam logic [7:0] WIDTH_LAST = (ACK_WIDTH <= 1) ? 8'd0 : 8'(ACK_WIDTH - 1);
    localparam logic [2:0] LAST_IDX   = 3'(PSX_POLL_BYTES - 1);

    logic psx_clk_lvl, psx_clk_rise, psx_clk_fall;
    logic cmd_lvl, cmd_rise, cmd_fall;
    logic att_lvl, att_rise, att_fall;

    psx_sync #(.RESET_VAL(1'b1)) u_sync_clk (
        .clk   (clk),
        .rst   (rst),
        .din   (psx_clk),
        .level (psx_clk_lvl),
        .rise  (psx_clk_rise),
        .fall  (psx_clk_fall)
    );

    psx_sync #(.RESET_VAL(1'b1)) u_sync_cmd (
        .clk   (clk),
        .rst   (rst),
        .din   (cmd),
        .level (cmd_lvl),
        .rise  (cmd_rise),
        .fall  (cmd_fall)
    );

    psx_sync #(.RESET_VAL(1'b1)) u_sync_att (
        .clk   (clk),
        .rst   (rst),
        .din   (att),
        .level (att_lvl),
        .rise  (att_rise),
        .fall  (att_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{psx_clk_lvl, cmd_rise, cmd_fall, att_lvl};

    psx_state_t  state;
    logic [2:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [7:0]  cnt;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic [15:0] snap;
    logic [7:0]  rx_next;

    assign rx_next = {cmd_lvl, rx[7:1]};

`ifdef PSX_PAD_ADDR_CHECK_EN
    logic addr_bad;
    assign addr_bad = ((byte_idx == 3'd0) && (rx_next != PSX_CMD_START)) ||
                      ((byte_idx == 3'd1) && (rx_next != PSX_CMD_POLL));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_idx  <= 3'd0;
            bit_idx   <= 3'd0;
            cnt       <= 8'd0;
            tx        <= PSX_HIZ_BYTE;
            rx        <= 8'd0;
            snap      <= 16'hFFFF;
            data      <= 1'b1;
            ack       <= 1'b1;
            cmd_byte  <= 8'd0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (att_rise) begin
                state   <= IDLE;
                data    <= 1'b1;
                ack     <= 1'b1;
                bit_idx <= 3'd0;
                cnt     <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (att_fall) begin
                            snap     <= btn;
                            tx       <= PSX_HIZ_BYTE;
                            byte_idx <= 3'd0;
                            bit_idx  <= 3'd0;
                            data     <= 1'b1;
                            ack      <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                    ACK_WAIT: begin
                        if (cnt == DELAY_LAST) begin
                            ack   <= 1'b0;
                            cnt   <= 8'd0;
                            state <= ACK_PULSE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ACK_PULSE: begin
                        if (cnt == WIDTH_LAST) begin
                            ack   <= 1'b1;
                            cnt   <= 8'd0;
                            state <= SHIFT;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase

                // Link edges keep being served while the ack countdown runs.
                if (state inside {SHIFT, ACK_WAIT, ACK_PULSE}) begin
                    if (psx_clk_fall) begin
                        data <= tx[bit_idx];
                    end
                    if (psx_clk_rise) begin
                        rx      <= rx_next;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            cmd_byte  <= rx_next;
                            cmd_valid <= 1'b1;
                            bit_idx   <= 3'd0;
                            ack       <= 1'b1;
                            cnt       <= 8'd0;
`ifdef PSX_PAD_ADDR_CHECK_EN
                            if (addr_bad) begin
                                data  <= 1'b1;
                                state <= IGNORE;
                            end else
`endif
                            if (byte_idx < LAST_IDX) begin
                                byte_idx <= byte_idx + 3'd1;
                                tx       <= psx_tx_byte(byte_idx + 3'd1, snap);
                                if (ACK_DELAY == 0) begin
                                    ack   <= 1'b0;
                                    state <= ACK_PULSE;
                                end else begin
                                    state <= ACK_WAIT;
                                end
                            end else begin
                                data  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
